// File: rtl/multicycle_control.sv
// multicycle_control
//   Multi-cycle control FSM for the 2-operand datapath. It sequences
//   FETCH -> DECODE -> EXECUTE -> MEM -> WRITEBACK and drives every
//   datapath enable from the current state and the opcode class that was
//   latched in DECODE.
//
// Ports
//   clk          rising-edge clock
//   clear        asynchronous active-low reset; forces every output to 0
//   opcode       decoded opcode (sampled only in DECODE)
//   memReady     memory completes the current request this cycle
//   aluZero      ALU result == 0 (used by BNEQ in EXECUTE)
//   irWrite      load instruction register
//   pcWrite      load PC
//   pcSrc        0 = PC+4, 1 = branch target
//   regWrite     register file write of Rd
//   aluSrcB      0 = Rs, 1 = immediate
//   aluOp        00 add, 01 sub, 10 pass B
//   memReq       memory request active
//   memWe        memory write (valid with memReq)
//   iorD         0 = address from PC, 1 = address from ALU
//   wbSel        0 = ALU result, 1 = memory data
//   illegalOp    one-cycle pulse in DECODE on an unknown opcode
//   state        current state, for debug
//
// Optional build macro CTRL_PERF_CNT_EN adds cycleCount / retiredCount
// performance counters (32-bit, wrap modulo 2^32).
module multicycle_control #(
  parameter int                    opCodeWidth = 6,
  parameter logic [opCodeWidth-1:0] OP_NOOP    = 6'd0,
  parameter logic [opCodeWidth-1:0] OP_ADD     = 6'd1,
  parameter logic [opCodeWidth-1:0] OP_ADDI    = 6'd2,
  parameter logic [opCodeWidth-1:0] OP_LW      = 6'd3,
  parameter logic [opCodeWidth-1:0] OP_SW      = 6'd4,
  parameter logic [opCodeWidth-1:0] OP_LI      = 6'd5,
  parameter logic [opCodeWidth-1:0] OP_BNEQ    = 6'd6
) (
  input  logic                   clk,
  input  logic                   clear,
  input  logic [opCodeWidth-1:0] opcode,
  input  logic                   memReady,
  input  logic                   aluZero,
  output logic                   irWrite,
  output logic                   pcWrite,
  output logic                   pcSrc,
  output logic                   regWrite,
  output logic                   aluSrcB,
  output logic [1:0]             aluOp,
  output logic                   memReq,
  output logic                   memWe,
  output logic                   iorD,
  output logic                   wbSel,
  output logic                   illegalOp,
  output logic [2:0]             state
`ifdef CTRL_PERF_CNT_EN
  ,
  output logic [31:0]            cycleCount,
  output logic [31:0]            retiredCount
`endif
);

  typedef enum logic [2:0] {
    S_FETCH     = 3'd0,
    S_DECODE    = 3'd1,
    S_EXECUTE   = 3'd2,
    S_MEM       = 3'd3,
    S_WRITEBACK = 3'd4
  } state_t;

  typedef enum logic [2:0] {
    C_NOOP = 3'd0,
    C_ADD  = 3'd1,
    C_ADDI = 3'd2,
    C_LW   = 3'd3,
    C_SW   = 3'd4,
    C_LI   = 3'd5,
    C_BNEQ = 3'd6
  } cls_t;

  state_t     st, nxt;
  cls_t       cls, dec_cls;
  logic       dec_ill;

  logic       ir_c, pcw_c, pcs_c, rw_c, sb_c, mreq_c, mwe_c, iord_c, wb_c, ill_c;
  logic [1:0] aop_c;

  // Opcode to class; unknown opcodes behave as NOOP and raise illegalOp.
  always_comb begin
    dec_cls = C_NOOP;
    dec_ill = 1'b0;
    case (opcode)
      OP_NOOP: dec_cls = C_NOOP;
      OP_ADD:  dec_cls = C_ADD;
      OP_ADDI: dec_cls = C_ADDI;
      OP_LW:   dec_cls = C_LW;
      OP_SW:   dec_cls = C_SW;
      OP_LI:   dec_cls = C_LI;
      OP_BNEQ: dec_cls = C_BNEQ;
      default: dec_ill = 1'b1;
    endcase
  end

  // State and class registers; class is only captured in DECODE so opcode
  // activity in any other state is ignored.
  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      st  <= S_FETCH;
      cls <= C_NOOP;
    end else begin
      st <= nxt;
      if (st == S_DECODE) cls <= dec_cls;
    end
  end

  always_comb begin
    nxt    = st;
    ir_c   = 1'b0;
    pcw_c  = 1'b0;
    pcs_c  = 1'b0;
    rw_c   = 1'b0;
    sb_c   = 1'b0;
    aop_c  = 2'b00;
    mreq_c = 1'b0;
    mwe_c  = 1'b0;
    iord_c = 1'b0;
    wb_c   = 1'b0;
    ill_c  = 1'b0;
    case (st)
      S_FETCH: begin
        mreq_c = 1'b1;
        if (memReady) begin
          ir_c  = 1'b1;
          pcw_c = 1'b1;
          nxt   = S_DECODE;
        end
      end
      S_DECODE: begin
        ill_c = dec_ill;
        nxt   = S_EXECUTE;
      end
      S_EXECUTE: begin
        case (cls)
          C_ADD: nxt = S_WRITEBACK;
          C_ADDI: begin
            sb_c = 1'b1;
            nxt  = S_WRITEBACK;
          end
          C_LI: begin
            sb_c  = 1'b1;
            aop_c = 2'b10;
            nxt   = S_WRITEBACK;
          end
          C_LW, C_SW: begin
            sb_c = 1'b1;
            nxt  = S_MEM;
          end
          C_BNEQ: begin
            // Subtract Rd - Rs; branch taken when the result is non-zero.
            aop_c = 2'b01;
            if (!aluZero) begin
              pcw_c = 1'b1;
              pcs_c = 1'b1;
            end
            nxt = S_FETCH;
          end
          default: nxt = S_FETCH;
        endcase
      end
      S_MEM: begin
        mreq_c = 1'b1;
        iord_c = 1'b1;
        mwe_c  = (cls == C_SW);
        if (memReady) nxt = (cls == C_LW) ? S_WRITEBACK : S_FETCH;
      end
      S_WRITEBACK: begin
        rw_c = 1'b1;
        wb_c = (cls == C_LW);
        nxt  = S_FETCH;
      end
      default: nxt = S_FETCH;
    endcase
  end

  // Gate with clear so a reset mid-request drops every enable immediately,
  // not just at the next register update.
  assign irWrite   = clear & ir_c;
  assign pcWrite   = clear & pcw_c;
  assign pcSrc     = clear & pcs_c;
  assign regWrite  = clear & rw_c;
  assign aluSrcB   = clear & sb_c;
  assign aluOp     = clear ? aop_c : 2'b00;
  assign memReq    = clear & mreq_c;
  assign memWe     = clear & mwe_c;
  assign iorD      = clear & iord_c;
  assign wbSel     = clear & wb_c;
  assign illegalOp = clear & ill_c;
  assign state     = st;

`ifdef CTRL_PERF_CNT_EN
  logic retire;
  assign retire = (nxt == S_FETCH) &&
                  ((st == S_EXECUTE) || (st == S_MEM) || (st == S_WRITEBACK));

  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      cycleCount   <= 32'd0;
      retiredCount <= 32'd0;
    end else begin
      cycleCount <= cycleCount + 32'd1;
      if (retire) retiredCount <= retiredCount + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_multicycle_control.sv
// Testbench for multicycle_control: per-cycle vector table checked through
// a scoreboard queue, plus hand-written reset and counter sequences.
module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       clear;
  logic [5:0] opcode;
  logic       memReady;
  logic       aluZero;
  logic       irWrite, pcWrite, pcSrc, regWrite, aluSrcB;
  logic [1:0] aluOp;
  logic       memReq, memWe, iorD, wbSel, illegalOp;
  logic [2:0] state;
`ifdef CTRL_PERF_CNT_EN
  logic [31:0] cycleCount, retiredCount;
`endif

  always #5 clk = ~clk;

  multicycle_control dut (
    .clk(clk),
    .clear(clear),
    .opcode(opcode),
    .memReady(memReady),
    .aluZero(aluZero),
    .irWrite(irWrite),
    .pcWrite(pcWrite),
    .pcSrc(pcSrc),
    .regWrite(regWrite),
    .aluSrcB(aluSrcB),
    .aluOp(aluOp),
    .memReq(memReq),
    .memWe(memWe),
    .iorD(iorD),
    .wbSel(wbSel),
    .illegalOp(illegalOp),
    .state(state)
`ifdef CTRL_PERF_CNT_EN
    ,
    .cycleCount(cycleCount),
    .retiredCount(retiredCount)
`endif
  );

  // Output bundle bit positions
  localparam logic [11:0] IR   = 12'h800;
  localparam logic [11:0] PCW  = 12'h400;
  localparam logic [11:0] PCS  = 12'h200;
  localparam logic [11:0] RW   = 12'h100;
  localparam logic [11:0] SB   = 12'h080;
  localparam logic [11:0] PASS = 12'h040;
  localparam logic [11:0] SUB  = 12'h020;
  localparam logic [11:0] MQ   = 12'h010;
  localparam logic [11:0] MW   = 12'h008;
  localparam logic [11:0] IO   = 12'h004;
  localparam logic [11:0] WB   = 12'h002;
  localparam logic [11:0] IL   = 12'h001;
  localparam logic [11:0] F    = IR | PCW | MQ;

  logic [11:0] act_out;
  assign act_out = {irWrite, pcWrite, pcSrc, regWrite, aluSrcB, aluOp,
                    memReq, memWe, iorD, wbSel, illegalOp};

  typedef struct {
    logic [5:0]  op;
    logic        rdy;
    logic        az;
    logic [2:0]  st;
    logic [11:0] out;
  } vec_t;

  vec_t        vecs[$];
  logic [14:0] sb_q[$];
  int          errors = 0;
  int          checks = 0;

  task automatic add(input logic [5:0] op, input logic rdy, input logic az,
                     input logic [2:0] st, input logic [11:0] out);
    vec_t v;
    v.op = op; v.rdy = rdy; v.az = az; v.st = st; v.out = out;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [14:0] exp;
    clear    = 1'b0;
    opcode   = 6'd1;
    memReady = 1'b1;
    aluZero  = 1'b0;

    // Reset held low for 3 cycles: everything quiet, state FETCH
    repeat (3) begin
      @(negedge clk);
      check("rst_outputs", 32'(act_out), 32'd0);
      check("rst_state", 32'(state), 32'd0);
    end
    memReady = 1'b0;
    clear    = 1'b1;

    // Vector table: inputs for a cycle and the state/outputs expected in it
    add(6'd0, 1'b0, 1'b0, 3'd0, MQ);
    // ADD
    add(6'd1, 1'b1, 1'b0, 3'd0, F);
    add(6'd1, 1'b1, 1'b0, 3'd1, 12'h000);
    add(6'd1, 1'b1, 1'b0, 3'd2, 12'h000);
    add(6'd1, 1'b1, 1'b0, 3'd4, RW);
    // LW with one fetch wait and two MEM waits
    add(6'd3, 1'b0, 1'b0, 3'd0, MQ);
    add(6'd3, 1'b1, 1'b0, 3'd0, F);
    add(6'd3, 1'b1, 1'b0, 3'd1, 12'h000);
    add(6'd3, 1'b1, 1'b0, 3'd2, SB);
    add(6'd3, 1'b0, 1'b0, 3'd3, MQ | IO);
    add(6'd3, 1'b0, 1'b0, 3'd3, MQ | IO);
    add(6'd3, 1'b1, 1'b0, 3'd3, MQ | IO);
    add(6'd3, 1'b1, 1'b0, 3'd4, RW | WB);
    // BNEQ taken
    add(6'd6, 1'b1, 1'b0, 3'd0, F);
    add(6'd6, 1'b1, 1'b0, 3'd1, 12'h000);
    add(6'd6, 1'b1, 1'b0, 3'd2, PCW | PCS | SUB);
    // BNEQ not taken
    add(6'd6, 1'b1, 1'b1, 3'd0, F);
    add(6'd6, 1'b1, 1'b1, 3'd1, 12'h000);
    add(6'd6, 1'b1, 1'b1, 3'd2, SUB);
    // SW
    add(6'd4, 1'b1, 1'b0, 3'd0, F);
    add(6'd4, 1'b1, 1'b0, 3'd1, 12'h000);
    add(6'd4, 1'b1, 1'b0, 3'd2, SB);
    add(6'd4, 1'b1, 1'b0, 3'd3, MQ | MW | IO);
    // Illegal opcode 63
    add(6'd63, 1'b1, 1'b0, 3'd0, F);
    add(6'd63, 1'b1, 1'b0, 3'd1, IL);
    add(6'd63, 1'b1, 1'b0, 3'd2, 12'h000);
    // ADDI, opcode switched to LW after DECODE must not matter
    add(6'd2, 1'b1, 1'b0, 3'd0, F);
    add(6'd2, 1'b1, 1'b0, 3'd1, 12'h000);
    add(6'd3, 1'b1, 1'b0, 3'd2, SB);
    add(6'd3, 1'b1, 1'b0, 3'd4, RW);
    // LI
    add(6'd5, 1'b1, 1'b0, 3'd0, F);
    add(6'd5, 1'b1, 1'b0, 3'd1, 12'h000);
    add(6'd5, 1'b1, 1'b0, 3'd2, SB | PASS);
    add(6'd5, 1'b1, 1'b0, 3'd4, RW);
    // NOOP
    add(6'd0, 1'b1, 1'b0, 3'd0, F);
    add(6'd0, 1'b1, 1'b0, 3'd1, 12'h000);
    add(6'd0, 1'b1, 1'b0, 3'd2, 12'h000);

    for (int i = 0; i < vecs.size(); i++) begin
      @(posedge clk);
      #1;
      opcode   = vecs[i].op;
      memReady = vecs[i].rdy;
      aluZero  = vecs[i].az;
      sb_q.push_back({vecs[i].st, vecs[i].out});
      @(negedge clk);
      exp = sb_q.pop_front();
      check($sformatf("vec%0d", i), 32'({state, act_out}), 32'(exp));
    end

    // Reset asserted while a LW sits in MEM with memReq high
    aluZero = 1'b0;
    @(posedge clk); #1; opcode = 6'd3; memReady = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    memReady = 1'b0;
    @(posedge clk); #1;
    check("mem_before_rst", 32'({state, memReq}), 32'({3'd3, 1'b1}));
    #2 clear = 1'b0;
    #1;
    check("rst_mid_outputs", 32'(act_out), 32'd0);
    check("rst_mid_state", 32'(state), 32'd0);
    @(negedge clk);
    clear    = 1'b1;
    memReady = 1'b0;
    @(posedge clk); #1;
    check("post_rst_fetch", 32'({state, memReq, regWrite}), 32'({3'd0, 1'b1, 1'b0}));

`ifdef CTRL_PERF_CNT_EN
    // ADD, LW, NOOP with zero wait: 4 + 5 + 3 cycles, three retirements
    @(negedge clk);
    clear    = 1'b0;
    memReady = 1'b1;
    opcode   = 6'd1;
    @(negedge clk);
    check("cnt_rst_cycle", cycleCount, 32'd0);
    check("cnt_rst_retired", retiredCount, 32'd0);
    clear = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk);
      #1;
      opcode = (k < 4) ? 6'd1 : ((k < 9) ? 6'd3 : 6'd0);
    end
    check("cnt_state", 32'(state), 32'd0);
    check("cnt_cycle", cycleCount, 32'd12);
    check("cnt_retired", retiredCount, 32'd3);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
